// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequencing controller for the bcd_convm digit-serial
// binary-to-BCD converter. Accepts one binary value per request handshake,
// issues the converter's request/next pulse train at a fixed spacing, collects
// one decimal digit per pulse (least-significant first) and returns the packed
// BCD word over a result handshake.
//
// Optional feature: define BCD_SEQ_LZ_BLANK_EN to blank leading zero digits
// (replaced by 4'hF, digit 0 never blanked) as the result is finalised.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; value latched into cv_bin on accept
// START | one-cycle converter request pulse, step timer loaded
// WAIT  | step timer counting down until the converter digit is settled
// CAPT  | digit stored into slot idx, error flag updated
// NEXT  | one-cycle next-quotient pulse, step timer reloaded
// DONE  | result presented, held until the consumer accepts it

module bcd_seq_ctrl #(
   parameter int BIN_W    = 27,
   parameter int NDIG     = 9,
   parameter int STEP_CYC = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [BIN_W-1:0]    req_bin,
   output logic                req_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [4*NDIG-1:0]   res_bcd,
   output logic                res_err,
   output logic                cv_req_pls,
   output logic [BIN_W-1:0]    cv_bin,
   output logic                cv_next_pls,
   input  logic [7:0]          cv_dec
);

   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_CYC - 1);
   // Leaving WAIT as the count goes 1 -> 0 places the capture exactly
   // STEP_CYC cycles after the pulse.
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_CAPT  = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   state_t              state_after_pls;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [4*NDIG-1:0]   bcd_q;
   logic                err_q;
   logic [BIN_W-1:0]    bin_q;
   logic [4*NDIG-1:0]   bcd_capt;
   logic [4*NDIG-1:0]   bcd_final;
   logic                accept;
   logic                dig_err;
   logic                unused_dec_hi;

   // Only the low nibble of the converter output carries the digit.
   assign unused_dec_hi = ^cv_dec[7:4];

   assign accept  = req_ready & req_valid;
   assign dig_err = (cv_dec[3:0] > 4'd9);

   // With a one-cycle step the digit is already due the cycle after the pulse.
   assign state_after_pls = (STEP_CYC == 1) ? S_CAPT : S_WAIT;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and handshake/pulse outputs; everything is held low in reset.
   always_comb begin
      state_nxt   = state_q;
      req_ready   = 1'b0;
      res_valid   = 1'b0;
      cv_req_pls  = 1'b0;
      cv_next_pls = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = ~reset;
            if (req_valid) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            cv_req_pls = ~reset;
            state_nxt  = state_after_pls;
         end
         S_WAIT: begin
            if (cnt_q == CNT_TC) begin
               state_nxt = S_CAPT;
            end
         end
         S_CAPT: begin
            state_nxt = (idx_q == IDX_LAST) ? S_DONE : S_NEXT;
         end
         S_NEXT: begin
            cv_next_pls = ~reset;
            state_nxt   = state_after_pls;
         end
         S_DONE: begin
            res_valid = ~reset;
            if (res_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Result word with the incoming digit dropped into slot idx.
   always_comb begin
      bcd_capt = bcd_q;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            bcd_capt[4*i +: 4] = cv_dec[3:0];
         end
      end
   end

`ifdef BCD_SEQ_LZ_BLANK_EN
   logic seen_nz;

   // Blank every digit above the most significant nonzero one; digit 0 stays.
   always_comb begin
      bcd_final = bcd_capt;
      seen_nz   = 1'b0;
      for (int i = NDIG - 1; i >= 1; i--) begin
         if (bcd_capt[4*i +: 4] != 4'h0) begin
            seen_nz = 1'b1;
         end
         if (!seen_nz) begin
            bcd_final[4*i +: 4] = 4'hF;
         end
      end
   end
`else
   assign bcd_final = bcd_capt;
`endif

   // Datapath: request latch, step timer, digit index and result capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         bcd_q <= '0;
         err_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  bin_q <= req_bin;
                  idx_q <= '0;
                  bcd_q <= '0;
                  err_q <= 1'b0;
               end
            end
            S_START, S_NEXT: begin
               cnt_q <= CNT_LOAD;
            end
            S_WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
            S_CAPT: begin
               if (dig_err) begin
                  err_q <= 1'b1;
               end
               if (idx_q == IDX_LAST) begin
                  bcd_q <= bcd_final;
               end else begin
                  bcd_q <= bcd_capt;
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign cv_bin  = bin_q;
   assign res_bcd = bcd_q;
   assign res_err = err_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Testbench for bcd_seq_ctrl: behavioural converter model (LSD-first, with
// optional bad-digit injection), arithmetic reference for the BCD result and
// cycle-exact checks of pulse timing, latency and result hold.

module tb_bcd_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [26:0] req_bin = '0;
   logic        req_ready;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [35:0] res_bcd;
   logic        res_err;
   logic        cv_req_pls;
   logic [26:0] cv_bin;
   logic        cv_next_pls;
   logic [7:0]  cv_dec;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          err_dig = -1;
   int unsigned m_val   = 0;
   int          m_k     = 0;
   logic [3:0]  m_d;
   logic [3:0]  m_junk;

   bcd_seq_ctrl #(.BIN_W(27), .NDIG(9), .STEP_CYC(7)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_bin     (req_bin),
      .req_ready   (req_ready),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_bcd     (res_bcd),
      .res_err     (res_err),
      .cv_req_pls  (cv_req_pls),
      .cv_bin      (cv_bin),
      .cv_next_pls (cv_next_pls),
      .cv_dec      (cv_dec)
   );

   always #5 clk = ~clk;

   // Converter model: each pulse presents the next decimal digit, LSD first.
   always @(negedge clk) begin
      if (cv_req_pls || cv_next_pls) begin
         if (cv_req_pls) begin
            m_val = 32'(cv_bin);
            m_k   = 0;
         end else begin
            m_val = m_val / 10;
            m_k   = m_k + 1;
         end
         m_d = 4'(m_val % 10);
         if (m_k == err_dig) m_d = 4'hA;
         m_junk = 4'($urandom_range(15));
         cv_dec = {m_junk, m_d};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] exp_bcd(input int unsigned v, input int edig);
      int unsigned r;
      logic [3:0]  d [9];
      logic [35:0] p;
      r = v;
      for (int i = 0; i < 9; i++) begin
         d[i] = 4'(r % 10);
         r    = r / 10;
         if (i == edig) d[i] = 4'hA;
      end
`ifdef BCD_SEQ_LZ_BLANK_EN
      begin
         int top;
         top = 0;
         for (int i = 0; i < 9; i++) if (d[i] != 4'h0) top = i;
         for (int i = 1; i < 9; i++) if (i > top) d[i] = 4'hF;
      end
`endif
      p = '0;
      for (int i = 0; i < 9; i++) p[4*i +: 4] = d[i];
      return p;
   endfunction

   task automatic check_reset_outs();
      check_val("rst_req_ready",   64'(req_ready),   64'd0);
      check_val("rst_res_valid",   64'(res_valid),   64'd0);
      check_val("rst_res_bcd",     64'(res_bcd),     64'd0);
      check_val("rst_res_err",     64'(res_err),     64'd0);
      check_val("rst_cv_req_pls",  64'(cv_req_pls),  64'd0);
      check_val("rst_cv_next_pls", 64'(cv_next_pls), 64'd0);
      check_val("rst_cv_bin",      64'(cv_bin),      64'd0);
   endtask

   // One full conversion starting at a negedge; returns at the negedge after
   // the result handshake, so consecutive calls run back to back.
   task automatic run_conv(input logic [26:0] v, input int edig, input int hold);
      int          waitc;
      int          first_valid;
      int          pulses;
      int          bad_pulse;
      int          busy_ready;
      int          stable_bad;
      logic [35:0] exp_b;
      logic [35:0] snap_b;
      logic        snap_e;
      err_dig = edig;
      exp_b   = exp_bcd(32'(v), edig);
      waitc   = 0;
      while (!req_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check_val("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_bin   = v;
      @(negedge clk);
      req_valid = 1'b0;
      req_bin   = 27'($urandom);
      first_valid = -1;
      pulses      = 0;
      bad_pulse   = 0;
      busy_ready  = 0;
      for (int n = 1; n <= 200; n++) begin
         if (n > 1) @(negedge clk);
         if (cv_req_pls)  pulses++;
         if (cv_next_pls) pulses++;
         if (cv_req_pls !== (n == 1)) bad_pulse++;
         if (cv_next_pls !== (n > 1 && n <= 65 && (n - 1) % 8 == 0)) bad_pulse++;
         if (req_ready) busy_ready++;
         if (res_valid) begin
            first_valid = n;
            break;
         end
      end
      check_val("latency",       64'(first_valid), 64'd73);
      check_val("pulse_timing",  64'(bad_pulse),   64'd0);
      check_val("pulse_count",   64'(pulses),      64'd9);
      check_val("busy_no_ready", 64'(busy_ready),  64'd0);
      check_val("cv_bin",        64'(cv_bin),      64'(v));
      check_val("res_bcd",       64'(res_bcd),     64'(exp_b));
      check_val("res_err",       64'(res_err),     64'(edig >= 0 && edig < 9));
      snap_b     = res_bcd;
      snap_e     = res_err;
      stable_bad = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!res_valid || res_bcd !== snap_b || res_err !== snap_e ||
             req_ready || cv_req_pls || cv_next_pls) stable_bad++;
      end
      if (hold > 0) check_val("done_hold_stable", 64'(stable_bad), 64'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_val("res_valid_drop", 64'(res_valid), 64'd0);
      check_val("req_ready_back", 64'(req_ready), 64'd1);
   endtask

   initial begin
      int stray;
      int rv;
      int re;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outs();
      reset = 1'b0;
      @(negedge clk);
      check_val("req_ready_after_reset", 64'(req_ready), 64'd1);

      run_conv(27'd91234567, -1, 20);
      run_conv(27'd134217727, -1, 0);
      run_conv(27'd0, -1, 3);
      run_conv(27'd86420135, 2, 1);
      run_conv(27'd86420135, -1, 0);

      // Reset in the WAIT phase of digit 4 (cycles 34..39 after acceptance).
      err_dig   = -1;
      req_valid = 1'b1;
      req_bin   = 27'd12345678;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (35) @(negedge clk);
      check_val("pre_reset_busy", 64'(req_ready), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outs();
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (cv_req_pls || cv_next_pls || res_valid) stray++;
      end
      check_val("no_pulse_after_reset", 64'(stray), 64'd0);
      run_conv(27'd12345678, -1, 0);

      for (int i = 0; i < 6; i++) begin
         rv = (i % 2 == 0) ? int'($urandom_range(134217727)) : int'($urandom_range(9999));
         re = ($urandom_range(2) == 0) ? int'($urandom_range(8)) : -1;
         run_conv(27'(rv), re, int'($urandom_range(4)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_seq_ctrl.md
# bcd_seq_ctrl

Sequencing controller for the `bcd_convm` digit-serial binary-to-BCD converter. It accepts a binary value from one requester over a valid/ready handshake. It then drives the converter's `bin_req_pls` / `next_quotient_pls` pulse train with fixed spacing, collects one decimal digit per step from `dec_out`, and returns the packed BCD result over a second valid/ready handshake. It sits between the display/report logic and `bcd_convm`, and is the only block that drives the converter's control pulses.

## Interface
- `BIN_W`, 27: binary input width; matches converter `bin_in`.
- `NDIG`, 9: digits collected per conversion (9 covers 2^27-1).
- `STEP_CYC`, 7: clock cycles from a converter pulse to capture of its digit; minimum 1.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: requester has a value on `req_bin`.
- `req_bin`  in  BIN_W: binary value to convert.
- `req_ready`  out  1: controller can accept a request.
- `res_valid`  out  1: `res_bcd` / `res_err` are valid.
- `res_ready`  in  1: consumer accepts the result.
- `res_bcd`  out  4*NDIG: packed BCD; digit i (10^i) at bits [4i+3:4i].
- `res_err`  out  1: at least one captured digit was greater than 9.
- `cv_req_pls`  out  1: to converter `bin_req_pls`.
- `cv_bin`  out  BIN_W: to converter `bin_in`.
- `cv_next_pls`  out  1: to converter `next_quotient_pls`.
- `cv_dec`  in  8: from converter `dec_out`; only [3:0] is used.

## Operation
- States: IDLE, START, WAIT, CAPT, NEXT, DONE.
- IDLE: `req_ready`=1. When `req_valid`&`req_ready`, latch `req_bin` into `cv_bin`, clear the digit index and `res_err`, then go to START.
- START: `cv_req_pls`=1 for exactly one cycle. Load the step counter with STEP_CYC-1, then go to WAIT.
- WAIT: decrement the counter. At 0, go to CAPT.
- CAPT: write `cv_dec[3:0]` into digit slot `idx`. Set `res_err` if the value exceeds 9. If `idx`==NDIG-1, go to DONE. Otherwise increment `idx` and go to NEXT.
- NEXT: `cv_next_pls`=1 for one cycle. Reload the counter, then go to WAIT.
- DONE: `res_valid`=1. `res_bcd` and `res_err` stay stable until `res_ready`=1, then go to IDLE.
- The converter contract is that each pulse yields the next digit, least-significant first.
- `cv_bin` is stable from START until the next accepted request.
- `req_ready` is 0 in every state except IDLE. Requests made while busy are not lost; the requester keeps `req_valid` asserted.
- Digits are 4-bit and unsigned; no arithmetic is done on them. `idx` is `$clog2(NDIG)` bits wide and never wraps past NDIG-1.
- Reset, including mid-conversion: return to IDLE on the next edge. No further converter pulses are issued. The partial result is discarded.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 in IDLE. `res_valid`=0, `res_bcd`=0, `res_err`=0, `cv_req_pls`=0, `cv_next_pls`=0, `cv_bin`=0.
- If the request is accepted at edge T:
  - `cv_req_pls` is high in cycle T+1.
  - Digit k is captured in cycle T+1+k*(STEP_CYC+1)+STEP_CYC.
  - `cv_next_pls` k (k=1..NDIG-1) is high in cycle T+1+k*(STEP_CYC+1).
- `res_valid` rises at T+1+NDIG*(STEP_CYC+1). With defaults this is T+73.
- Pulse spacing is STEP_CYC+1 cycles (8 by default). There are NDIG pulses in total: 1 `cv_req_pls` and NDIG-1 `cv_next_pls`.
- Result handshake at edge R: `res_valid` is 0 and `req_ready` is 1 from R+1. A new request is accepted at the earliest at edge R+1. Back-to-back throughput is one conversion per NDIG*(STEP_CYC+1)+2 cycles.

## Configuration
- `BCD_SEQ_LZ_BLANK_EN` defined: when entering DONE, every digit above the most significant nonzero digit is replaced with 4'hF. Digit 0 is never blanked. `res_err` is unaffected.
- Not defined: `res_bcd` holds the raw captured digits, leading zeros included.

## Test plan
- Bench uses `bcd_convm` or a model honouring the LSD-first contract; STEP_CYC=7.
- `req_bin`=91234567 accepted at T -> `res_valid` at T+73; `res_bcd`=36'h0_9123_4567 (macro: 36'hF_9123_4567); `res_err`=0; exactly 1 `cv_req_pls` and 8 `cv_next_pls`, 8 cycles apart.
- `req_bin`=134217727 -> `res_bcd`=36'h1_3421_7727. `req_bin`=0 -> 36'h0_0000_0000 (macro: 36'hF_FFFF_FFF0).
- `res_ready` held 0 for 20 cycles in DONE -> `res_valid`, `res_bcd`, and `res_err` stable; `req_ready`=0; no converter pulses. Release -> IDLE next cycle.
- `reset` asserted in WAIT of digit 4 -> next cycle all outputs at reset values; no pulse afterward. A new request then converts correctly.
- Converter model returns 4'hA for digit 2 -> `res_err`=1 and digit 2 of `res_bcd`=4'hA; the next conversion clears `res_err`.
